// File: rtl/fpu_decode_queue.sv
// fpu_decode_queue: decodes raw FP instructions on entry and buffers them in a FIFO for FPU issue
package fpu_decode_queue_pkg;
  typedef enum logic [4:0] {
    FPU_NOP, FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_SQRT,
    FPU_MADD, FPU_MSUB, FPU_NMSUB, FPU_NMADD,
    FPU_SGNJ, FPU_SGNJ_N, FPU_SGNJ_X, FPU_MIN, FPU_MAX,
    FPU_LE, FPU_LT, FPU_EQ,
    FPU_FLOAT2INT, FPU_FLOAT2INT_U, FPU_INT2FLOAT, FPU_INT2FLOAT_U,
    FPU_MOVE_FLOAT2INT, FPU_FCLASS, FPU_MOVE_INT2FLOAT
  } fpu_op_e;
endpackage

module fpu_decode_queue
  import fpu_decode_queue_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter bit ENABLE_D       = 1'b0,
  parameter bit ENABLE_DIVSQRT = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       instr_valid_i,
  output logic                       instr_ready_o,
  input  logic [31:0]                instr_i,
  input  logic [2:0]                 frm_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output fpu_op_e                    out_op_o,
  output logic [2:0]                 out_rm_o,
  output logic [1:0]                 out_fmt_o,
  output logic [4:0]                 out_rs1_o,
  output logic [4:0]                 out_rs2_o,
  output logic [4:0]                 out_rs3_o,
  output logic [4:0]                 out_rd_o,
  output logic                       out_rs1_int_o,
  output logic                       out_rd_int_o,
  output logic                       out_illegal_o,
  output logic [31:0]                out_instr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef struct packed {
    fpu_op_e     op;
    logic [2:0]  rm;
    logic [1:0]  fmt;
    logic [4:0]  rs1, rs2, rs3, rd;
    logic        rs1_int, rd_int, illegal;
    logic [31:0] instr;
  } entry_t;
  entry_t mem [DEPTH];
  entry_t dec, head;
  fpu_op_e op53;
  logic [PW-1:0] wp, rp;
  logic push, pop, fmt_bad;
  logic [2:0] f3;
  logic [4:0] f5, rs2;
  assign f3 = instr_i[14:12];
  assign f5 = instr_i[31:27];
  assign rs2 = instr_i[24:20];
  assign fmt_bad = instr_i[26] || (instr_i[26:25] == 2'b01 && !ENABLE_D);
  always_comb begin
    op53 = FPU_NOP;
    case (f5)
      5'b00000: op53 = FPU_ADD;
      5'b00001: op53 = FPU_SUB;
      5'b00010: op53 = FPU_MUL;
      5'b00011: op53 = FPU_DIV;
      5'b01011: op53 = rs2 == 5'd0 ? FPU_SQRT : FPU_NOP;
      5'b00100: op53 = f3 == 3'd0 ? FPU_SGNJ : f3 == 3'd1 ? FPU_SGNJ_N : f3 == 3'd2 ? FPU_SGNJ_X : FPU_NOP;
      5'b00101: op53 = f3 == 3'd0 ? FPU_MIN : f3 == 3'd1 ? FPU_MAX : FPU_NOP;
      5'b10100: op53 = f3 == 3'd0 ? FPU_LE : f3 == 3'd1 ? FPU_LT : f3 == 3'd2 ? FPU_EQ : FPU_NOP;
      5'b11000: op53 = rs2 == 5'd0 ? FPU_FLOAT2INT : rs2 == 5'd1 ? FPU_FLOAT2INT_U : FPU_NOP;
      5'b11010: op53 = rs2 == 5'd0 ? FPU_INT2FLOAT : rs2 == 5'd1 ? FPU_INT2FLOAT_U : FPU_NOP;
      5'b11100: op53 = rs2 != 5'd0 ? FPU_NOP : f3 == 3'd0 ? FPU_MOVE_FLOAT2INT : f3 == 3'd1 ? FPU_FCLASS : FPU_NOP;
      5'b11110: op53 = rs2 == 5'd0 && f3 == 3'd0 ? FPU_MOVE_INT2FLOAT : FPU_NOP;
      default: op53 = FPU_NOP;
    endcase
  end
  always_comb begin
    dec = '0;
    dec.rm = f3;
    dec.fmt = instr_i[26:25];
    dec.rs1 = instr_i[19:15];
    dec.rs2 = rs2;
    dec.rs3 = f5;
    dec.rd = instr_i[11:7];
    dec.instr = instr_i;
    dec.illegal = 1'b1;
    case (instr_i[6:0])
      7'h07, 7'h27: dec.illegal = !(f3 == 3'b010 || (f3 == 3'b011 && ENABLE_D));
      7'h43, 7'h47, 7'h4b, 7'h4f: begin
        dec.op = instr_i[3] ? (instr_i[2] ? FPU_NMADD : FPU_NMSUB) : (instr_i[2] ? FPU_MSUB : FPU_MADD);
        dec.illegal = fmt_bad;
      end
      7'h53: begin
        dec.op = op53;
        dec.illegal = fmt_bad || op53 == FPU_NOP || (!ENABLE_DIVSQRT && op53 inside {FPU_DIV, FPU_SQRT});
      end
      default: dec.illegal = 1'b1;
    endcase
    // Dynamic rounding (111) resolves to the frm captured now, not at issue time
    if (dec.op inside {FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_SQRT, FPU_MADD, FPU_MSUB, FPU_NMSUB,
                       FPU_NMADD, FPU_FLOAT2INT, FPU_FLOAT2INT_U, FPU_INT2FLOAT, FPU_INT2FLOAT_U}) begin
      dec.rm = f3 == 3'b111 ? frm_i : f3;
      dec.illegal = dec.illegal || dec.rm > 3'b100;
    end
    dec.rs1_int = dec.op inside {FPU_INT2FLOAT, FPU_INT2FLOAT_U, FPU_MOVE_INT2FLOAT};
    dec.rd_int = dec.op inside {FPU_FLOAT2INT, FPU_FLOAT2INT_U, FPU_MOVE_FLOAT2INT, FPU_FCLASS,
                                FPU_LE, FPU_LT, FPU_EQ};
  end
  assign instr_ready_o = rst_ni && count_o != FULL;
  assign out_valid_o = count_o != '0;
  assign push = instr_valid_i && instr_ready_o && !flush_i;
  assign pop = out_valid_o && out_ready_i && !flush_i;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wp <= '0;
      rp <= '0;
      count_o <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count_o <= count_o + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wp] <= dec;
  end
  assign head = out_valid_o ? mem[rp] : '0;
  assign out_op_o = head.op;
  assign out_rm_o = head.rm;
  assign out_fmt_o = head.fmt;
  assign out_rs1_o = head.rs1;
  assign out_rs2_o = head.rs2;
  assign out_rs3_o = head.rs3;
  assign out_rd_o = head.rd;
  assign out_rs1_int_o = head.rs1_int;
  assign out_rd_int_o = head.rd_int;
  assign out_illegal_o = head.illegal;
  assign out_instr_o = head.instr;
endmodule

// File: doc/fpu_decode_queue.md
Name: fpu_decode_queue

Overview:
- Parametrised, buffered successor to the combinational FP instruction decoder.
- Accepts raw 32-bit instructions over a valid/ready handshake and fully decodes each one on entry: FP op, resolved rounding mode, format, register indices, int/fp register-file selects and an illegal flag.
- Stores decoded entries in a DEPTH-entry FIFO for the FPU issue logic.
- Sits between the ibex ID stage and the FPU. Illegal instructions are queued with a flag so exceptions stay in program order.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2 to 16.
- ENABLE_D, 0, 1 = accept double format (fmt=01, FLD/FSD); 0 = those encodings are illegal.
- ENABLE_DIVSQRT, 1, 0 = FDIV/FSQRT are decoded as illegal.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- instr_valid_i  in  1  upstream instruction valid
- instr_ready_o  out  1  queue can accept an instruction
- instr_i  in  32  raw instruction
- frm_i  in  3  fcsr.frm dynamic rounding mode, sampled on push
- flush_i  in  1  discard all entries
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  consumer pops head
- out_op_o  out  fpu_op_e  decoded op
- out_rm_o  out  3  resolved rounding mode / funct3
- out_fmt_o  out  2  format field
- out_rs1_o, out_rs2_o, out_rs3_o, out_rd_o  out  5 each  register indices
- out_rs1_int_o  out  1  rs1 read from integer RF
- out_rd_int_o  out  1  rd written to integer RF
- out_illegal_o  out  1  illegal FP encoding
- out_instr_o  out  32  original instruction, for mtval
- count_o  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (rst_ni low at a clock edge): pointers and count go to 0.
  - out_valid_o=0, count_o=0.
  - instr_ready_o=0 while rst_ni is low, 1 afterwards.
- Push: occurs when instr_valid_i && instr_ready_o. instr_ready_o = rst_ni && (count < DEPTH), with no combinational dependence on out_ready_i.
  - A push when full is refused, even if a pop happens in the same cycle.
- Pop: occurs when out_valid_o && out_ready_i. out_valid_o = (count != 0).
- Latency: an entry pushed at edge N is visible at the head after edge N; there is no input-to-output bypass.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo DEPTH.
- When empty, head outputs read as: op = FPU_NOP, all other fields 0.
- flush_i: on the next edge count=0 and pointers=0. A push presented in the flush cycle is dropped. Flush has priority over push and pop.
- Decode is performed at push time; frm_i is captured into the entry.
- Non-FP opcodes: op = FPU_NOP, illegal=1.
- FLW/FSW (funct3=010): op = FPU_NOP, legal. FLD/FSD (funct3=011): legal only if ENABLE_D. Other widths: illegal.
- fmt is instr[26:25]. 00 is legal; 01 is legal iff ENABLE_D; 10 and 11 are illegal.
- R4 opcodes 43/47/4B/4F map to FPU_MADD, FPU_MSUB, FPU_NMSUB, FPU_NMADD. rs3 = instr[31:27].
- OP-FP (0x53) is decoded on funct5 = instr[31:27]:
  - 00000 ADD, 00001 SUB, 00010 MUL, 00011 DIV.
  - 01011 SQRT: rs2 must be 0, otherwise illegal.
  - 00100 SGNJ: funct3 000/001/010 → SGNJ/SGNJ_N/SGNJ_X.
  - 00101 MIN/MAX: funct3 000/001.
  - 10100 CMP: funct3 000 LE, 001 LT, 010 EQ.
  - 11000 FLOAT2INT / FLOAT2INT_U: rs2 = 0/1.
  - 11010 INT2FLOAT / INT2FLOAT_U: rs2 = 0/1.
  - 11100 with rs2=0: funct3 000 MOVE_FLOAT2INT, 001 FCLASS.
  - 11110 with rs2=0 and funct3=000: MOVE_INT2FLOAT.
  - Any other sub-encoding: op = FPU_NOP, illegal=1.
- Rounding mode applies to ADD, SUB, MUL, DIV, SQRT, R4 ops and CVT ops.
  - rm = funct3; if rm=111, use the captured frm_i.
  - A resolved rm of 101, 110 or 111 sets illegal=1.
  - For all other ops, out_rm_o = funct3.
- rs1_int=1 for INT2FLOAT*, MOVE_INT2FLOAT.
- rd_int=1 for FLOAT2INT*, MOVE_FLOAT2INT, FCLASS, CMP.
- When ENABLE_DIVSQRT=0: DIV and SQRT are illegal.

Test Plan:
- Reset, then push FADD.S 0x00208053 (rm=000) → after 1 edge: out_valid_o=1, op=FPU_ADD, rm=000, rs1=1, rs2=2, rd=0, illegal=0, count_o=1.
- Push DEPTH=4 instructions with out_ready_i=0 → instr_ready_o=0 and count_o=4. Fifth push with a simultaneous pop is refused. Pops return entries in order; pointers wrap correctly over 10 push/pop cycles.
- FMUL.S with rm=111 and frm_i=001 → out_rm_o=001. Same instruction with frm_i=101 → illegal=1.
- FCVT.W.S with rs2=0 → FPU_FLOAT2INT, rd_int=1. FSQRT.S with rs2=3 → illegal=1. Opcode 0x33 → FPU_NOP, illegal=1.
- FADD.D (fmt=01) with ENABLE_D=0 → illegal=1; with ENABLE_D=1 → legal, out_fmt_o=01. FDIV.S with ENABLE_DIVSQRT=0 → illegal=1.
- Three entries queued; assert flush_i together with a push → next cycle count_o=0, out_valid_o=0. Drive rst_ni=0 mid-stream → same result, and instr_ready_o=0 while reset is held.
